// File: rtl/shift_pipe.sv
// Pipelined log barrel shifter (SLL/SRL/SRA/ROR) with tag sideband and valid/ready flow control.
// Define SHIFT_PIPE_STICKY_EN to drive out_sticky with the OR of all discarded bits.
module shift_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_sticky
);

  localparam int AmtW  = $clog2(WIDTH);
  localparam int Depth = int'(PIPE_DEPTH);
  localparam int Last  = Depth - 1;

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;

  // First mux level handled by stage s; levels run largest shift first.
  function automatic int lvl_lo(input int s);
    return (s * AmtW) / Depth;
  endfunction

  function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] d,
                                                 input logic [1:0] op, input int sh);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] r;
    ones = '1;
    unique case (op)
      OpSll:   r = d << sh;
      OpSrl:   r = d >> sh;
      OpSra:   r = (d >> sh) | (d[WIDTH-1] ? ~(ones >> sh) : '0);
      default: r = (d >> sh) | (d << (WIDTH - sh));
    endcase
    return r;
  endfunction

`ifdef SHIFT_PIPE_STICKY_EN
  function automatic logic lost_bits(input logic [WIDTH-1:0] d, input logic [1:0] op,
                                     input int sh);
    logic [WIDTH-1:0] ones;
    logic             r;
    ones = '1;
    unique case (op)
      OpSll:        r = |(d & ~(ones >> sh));
      OpSrl, OpSra: r = |(d & ~(ones << sh));
      default:      r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  logic [Depth-1:0]            valid_q, load, src_valid;
  logic [Depth-1:0][WIDTH-1:0] data_q, data_d, src_data;
  logic [Depth-1:0][AmtW-1:0]  amt_q, src_amt;
  logic [Depth-1:0][1:0]       op_q, src_op;
  logic [Depth-1:0][TAG_W-1:0] tag_q, src_tag;
`ifdef SHIFT_PIPE_STICKY_EN
  logic [Depth-1:0]            sticky_q, sticky_d, src_sticky;
`endif

  for (genvar s = 0; s < Depth; s++) begin : g_src
    if (s == 0) begin : g_head
      assign src_valid[s] = in_valid;
      assign src_data[s]  = in_data;
      assign src_amt[s]   = in_amt;
      assign src_op[s]    = in_op;
      assign src_tag[s]   = in_tag;
`ifdef SHIFT_PIPE_STICKY_EN
      assign src_sticky[s] = 1'b0;
`endif
    end else begin : g_body
      assign src_valid[s] = valid_q[s-1];
      assign src_data[s]  = data_q[s-1];
      assign src_amt[s]   = amt_q[s-1];
      assign src_op[s]    = op_q[s-1];
      assign src_tag[s]   = tag_q[s-1];
`ifdef SHIFT_PIPE_STICKY_EN
      assign src_sticky[s] = sticky_q[s-1];
`endif
    end
  end

  // A stage may load if it or any stage downstream of it has a hole, or the output drains.
  always_comb begin
    load = '0;
    for (int s = 0; s < Depth; s++) begin
      load[s] = out_ready | (((~valid_q) >> s) != '0);
    end
  end

  assign in_ready = load[0];

  always_comb begin
    data_d = src_data;
`ifdef SHIFT_PIPE_STICKY_EN
    sticky_d = src_sticky;
`endif
    for (int s = 0; s < Depth; s++) begin
      for (int l = 0; l < AmtW; l++) begin
        if (l >= lvl_lo(s) && l < lvl_lo(s + 1) && src_amt[s][AmtW-1-l]) begin
`ifdef SHIFT_PIPE_STICKY_EN
          sticky_d[s] = sticky_d[s] | lost_bits(data_d[s], src_op[s], 1 << (AmtW - 1 - l));
`endif
          data_d[s] = shift_lvl(data_d[s], src_op[s], 1 << (AmtW - 1 - l));
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q  <= '0;
      data_q   <= '0;
      amt_q    <= '0;
      op_q     <= '0;
      tag_q    <= '0;
`ifdef SHIFT_PIPE_STICKY_EN
      sticky_q <= '0;
`endif
    end else begin
      for (int s = 0; s < Depth; s++) begin
        if (load[s]) begin
          valid_q[s] <= src_valid[s];
          // Payload only moves with a real entry, so an idle output keeps its last value.
          if (src_valid[s]) begin
            data_q[s]   <= data_d[s];
            amt_q[s]    <= src_amt[s];
            op_q[s]     <= src_op[s];
            tag_q[s]    <= src_tag[s];
`ifdef SHIFT_PIPE_STICKY_EN
            sticky_q[s] <= sticky_d[s];
`endif
          end
        end
      end
    end
  end

  // Amount and op of the output stage are never consumed.
  logic unused_last;
  assign unused_last = ^{amt_q[Last], op_q[Last]};

  assign out_valid = valid_q[Last];
  assign out_data  = data_q[Last];
  assign out_tag   = tag_q[Last];
`ifdef SHIFT_PIPE_STICKY_EN
  assign out_sticky = sticky_q[Last];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, PIPE_DEPTH=2): directed cases, backpressure,
// mid-flight reset and a randomized run against a queue-based reference model.
module tb_shift_pipe;

`ifdef SHIFT_PIPE_STICKY_EN
  localparam bit StickyEn = 1'b1;
`else
  localparam bit StickyEn = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_sticky;

  shift_pipe #(
    .WIDTH(32),
    .PIPE_DEPTH(2),
    .TAG_W(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_sticky(out_sticky)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        s;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [3:0] dtag = 4'd1;

  // Reference: view the operand as part of a wider word and read the window back.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] x,
                                            input int amt);
    logic [63:0] w;
    case (op)
      2'b00:   w = {32'b0, x} << amt;
      2'b01:   w = {32'b0, x} >> amt;
      2'b10:   w = {{32{x[31]}}, x} >> amt;
      default: w = {x, x} >> amt;
    endcase
    return w[31:0];
  endfunction

  function automatic logic ref_sticky(input logic [1:0] op, input logic [31:0] x, input int amt);
    logic [63:0] w;
    if (!StickyEn || amt == 0) return 1'b0;
    case (op)
      2'b00: begin
        w = {32'b0, x} << amt;
        return w[63:32] != 32'b0;
      end
      2'b01, 2'b10: begin
        w = {x, 32'b0} >> amt;
        return w[31:0] != 32'b0;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One cycle: sample at negedge (retire then accept), return just after the next posedge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clock);
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", {63'b0, out_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", {32'b0, out_data}, {32'b0, e.d});
        check("sb_tag", {60'b0, out_tag}, {60'b0, e.t});
        check("sb_sticky", {63'b0, out_sticky}, {63'b0, e.s});
      end
    end
    acc = reset && in_valid && in_ready;
    if (acc) begin
      e.d = ref_shift(in_op, in_data, int'(in_amt));
      e.t = in_tag;
      e.s = ref_sticky(in_op, in_data, int'(in_amt));
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] x,
                          input logic [4:0] amt, input logic [31:0] exp_d, input logic exp_s);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = x;
    in_amt   = amt;
    in_tag   = dtag;
    @(negedge clock);
    check({name, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    check({name, "_early"}, {63'b0, out_valid}, 64'd0);
    @(posedge clock);
    @(negedge clock);
    check({name, "_valid"}, {63'b0, out_valid}, 64'd1);
    check({name, "_data"}, {32'b0, out_data}, {32'b0, exp_d});
    check({name, "_tag"}, {60'b0, out_tag}, {60'b0, dtag});
    check({name, "_sticky"}, {63'b0, out_sticky}, {63'b0, exp_s});
    @(posedge clock);
    #1;
    dtag = dtag + 4'd1;
  endtask

  initial begin
    bit acc;
    int t;
    int n_acc;
    int cyc;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data", {32'b0, out_data}, 64'd0);
    check("rst_out_tag", {60'b0, out_tag}, 64'd0);
    check("rst_out_sticky", {63'b0, out_sticky}, 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clock);
    #1;

    // Directed datapath cases.
    directed("sra_neg", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    directed("srl_neg", 2'b01, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    directed("sll_31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    directed("sll_0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
    directed("ror_8", 2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 1'b0);
    directed("ror_0", 2'b11, 32'hCAFE_F00D, 5'd0, 32'hCAFE_F00D, 1'b0);
    directed("stk_srl1", 2'b01, 32'h0000_0011, 5'd4, 32'h0000_0001, StickyEn);
    directed("stk_srl0", 2'b01, 32'h0000_0010, 5'd4, 32'h0000_0001, 1'b0);
    directed("stk_sll1", 2'b00, 32'hC000_0000, 5'd1, 32'h8000_0000, StickyEn);

    // Backpressure: tags 1..5 with the consumer stalled.
    out_ready = 1'b0;
    t = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (t <= 5);
      in_tag   = 4'(t);
      in_op    = 2'b00;
      in_data  = 32'h1;
      in_amt   = 5'(t);
      tick(acc);
      if (acc) t++;
      if (c >= 1) begin
        check("bp_hold_valid", {63'b0, out_valid}, 64'd1);
        check("bp_hold_tag", {60'b0, out_tag}, 64'd1);
        check("bp_hold_data", {32'b0, out_data}, 64'd2);
      end
    end
    check("bp_accepts", 64'(t - 1), 64'd2);
    check("bp_in_ready", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = (t <= 5);
      in_tag   = 4'(t);
      in_amt   = 5'(t);
      check("bp_drain_valid", {63'b0, out_valid}, 64'd1);
      check("bp_drain_tag", {60'b0, out_tag}, 64'(k));
      tick(acc);
      if (acc) t++;
    end
    in_valid = 1'b0;
    check("bp_empty", {63'b0, out_valid}, 64'd0);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Reset with two entries in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_tag   = 4'hA + 4'(k);
      in_op    = 2'b11;
      in_data  = 32'h5A5A_0000 + 32'(k);
      in_amt   = 5'd3;
      tick(acc);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    sb.delete();
    check("mid_rst_valid", {63'b0, out_valid}, 64'd0);
    check("mid_rst_data", {32'b0, out_data}, 64'd0);
    check("mid_rst_tag", {60'b0, out_tag}, 64'd0);
    reset     = 1'b1;
    out_ready = 1'b1;
    check("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick(acc);
      check("mid_rst_no_out", {63'b0, out_valid}, 64'd0);
    end

    // Randomized regression.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      in_op     = 2'($urandom_range(0, 3));
      in_amt    = 5'($urandom_range(0, 31));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc);
      if (acc) n_acc++;
      cyc++;
    end
    check("rand_accepts", 64'(n_acc), 64'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) tick(acc);
    check("rand_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter. Successor to the team's 32-bit combinational left/right logical/arithmetic shifter.
- Adds generic width, configurable pipeline depth, rotate mode, a tag sideband and a valid/ready handshake with backpressure.
- Sits between the operand-read stage and the result-writeback stage of the functional unit. Feeds the ALU result mux and the FP normaliser.

Parameters:
- WIDTH, 32, data width; power of 2, minimum 8.
- PIPE_DEPTH, 2, number of register stages, range 1..log2(WIDTH). Equals latency in cycles.
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept this cycle.
- in_data  input  WIDTH  operand X.
- in_amt  input  log2(WIDTH)  shift amount, 0..WIDTH-1.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  passed through unchanged.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_data  output  WIDTH  result Z.
- out_tag  output  TAG_W  tag of the result.
- out_sticky  output  1  OR of discarded bits (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-low on `reset`.
- Reset state: while reset=0 at a clock edge, all stage valid bits clear.
  - out_valid=0, out_data=0, out_tag=0, out_sticky=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight entry; no partial outputs appear.
- Transfers: a transfer occurs on a clock edge where valid&ready=1, on either side.
- Datapath: log-shifter of log2(WIDTH) mux levels, largest shift first. The levels are split across PIPE_DEPTH register stages as evenly as possible; the last stage is always the output register. Placement is not externally visible.
- Latency: exactly PIPE_DEPTH cycles from input transfer to out_valid=1 when there is no stall. Throughput 1 op/cycle.
- Arithmetic:
  - SLL: zero-fill from the LSB end.
  - SRL: zero-fill from the MSB end.
  - SRA: fill with in_data[WIDTH-1].
  - ROR: bits leaving the LSB re-enter at the MSB.
  - Shifting left is not done by two's-complementing the amount; SLL uses its own fill path.
  - amt=0 returns in_data unchanged for all ops. No amount is out of range, since in_amt width bounds it to WIDTH-1.
- Pipeline control (bubble-collapsing):
  - Stage k loads when it is empty or stage k+1 loads this cycle; the output stage loads when empty or out_ready=1.
  - in_ready = stage-0 load condition. in_ready must not combinationally depend on in_valid.
  - Capacity is PIPE_DEPTH entries. When all are full and out_ready=0, in_ready=0.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_tag and out_sticky hold stable.
- Ordering: results leave in acceptance order. Tags are never reordered or dropped.
- Simultaneous events: when the pipeline is full and out_ready=1 in the same cycle as in_valid=1, the input is accepted and the output retired on the same edge.

Optional Feature:
- Macro: SHIFT_PIPE_STICKY_EN.
- Defined: out_sticky is registered with its result and is the OR of all bits discarded by the operation.
  - SLL: bits shifted past the MSB.
  - SRL/SRA: bits shifted past the LSB.
  - ROR: always 0. amt=0: always 0.
  - Computed per mux level and accumulated through the stages; it adds no latency.
- Undefined: out_sticky is tied to 0 and no sticky logic is synthesised. The port remains present.

Test Plan (WIDTH=32, PIPE_DEPTH=2, out_ready=1 unless stated):
- SRA, X=0x80000000, amt=4 -> out_data=0xF8000000 exactly 2 cycles after the accept. SRL with the same X and amt -> 0x08000000.
- SLL, X=0x00000001, amt=31 -> 0x80000000. SLL, X=0xDEADBEEF, amt=0 -> 0xDEADBEEF. ROR, X=0x12345678, amt=8 -> 0x78123456.
- Backpressure:
  - Stimulus: stream tags 1..5 back-to-back with out_ready=0.
  - Required: in_ready falls after 2 accepts; out_data/out_tag stay stable while stalled.
  - Then raise out_ready: tags emerge 1..5 in order, one per cycle, with no loss or duplication.
- Reset mid-operation: 2 ops in flight, reset=0 for one edge -> out_valid=0 the next cycle, nothing from those ops ever appears, and in_ready=1 once reset=1.
- Sticky (macro defined):
  - SRL, X=0x00000011, amt=4 -> out_data=0x00000001, out_sticky=1.
  - SRL, X=0x00000010, amt=4 -> out_sticky=0.
  - SLL, X=0xC0000000, amt=1 -> out_sticky=1.
  - Macro undefined: out_sticky=0 for all of these.
- Random regression: 10k ops with random ops, amounts and data, and random in_valid/out_ready -> every result and tag matches a reference model, in order.
